// File: rtl/scratchpad_param_pkg.sv
// Shared types and config-word layout helpers for the parametrised scratchpad.
// Config word layout: {dwell[7:0], en[NUM_BG-1:0], sel[NUM_BG-1:0]}.
package scratchpad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DWELL_W = 8;
    localparam int SEL_LSB = 0;

    function automatic int cfg_width(input int num_bg);
        return DWELL_W + 2 * num_bg;
    endfunction

    function automatic int en_lsb(input int num_bg);
        return num_bg;
    endfunction

    function automatic int dwell_lsb(input int num_bg);
        return 2 * num_bg;
    endfunction

    // Ceiling log2 that never returns zero, so it is safe as a vector width.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/scratchpad_param_bank.sv
// One scratchpad bank: single-port, read-first synchronous RAM with 1-cycle read latency.
// Storage is deliberately left unreset; only the read pipeline is cleared by rst.
module spm_bank #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Reading through the non-blocking write gives the old word when we and re collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/scratchpad_param.sv
// Parametrised scratchpad top: config buffer, ownership sequencer and per-bank port muxing
// between the switch (CGRA) ports and the single shared external port.
module scratchpad_param
    import scratchpad_pkg::*;
#(
    parameter int NUM_BG    = 8,
    parameter int DW        = 32,
    parameter int AW        = 8,
    parameter int CFG_DEPTH = 16,
    parameter int CW        = cfg_width(NUM_BG),
    parameter int BW        = clog2_min1(NUM_BG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_wdata,
    input  logic                 cfg_clr,
    input  logic                 start,
    input  logic [7:0]           repeat_n,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_full,
    output logic [CW-1:0]        cfg_active,
    input  logic [NUM_BG-1:0]    sw_we,
    input  logic [NUM_BG-1:0]    sw_re,
    input  logic [NUM_BG*AW-1:0] sw_addr,
    input  logic [NUM_BG*DW-1:0] sw_wdata,
    output logic [NUM_BG*DW-1:0] sw_rdata,
    output logic [NUM_BG-1:0]    sw_rvalid,
    input  logic                 ex_we,
    input  logic                 ex_re,
    input  logic [BW-1:0]        ex_bank,
    input  logic [AW-1:0]        ex_addr,
    input  logic [DW-1:0]        ex_wdata,
    output logic [DW-1:0]        ex_rdata,
    output logic                 ex_rvalid,
    output logic                 ex_err
);

    localparam int DWELL_LSB = dwell_lsb(NUM_BG);
    localparam int EN_LSB    = en_lsb(NUM_BG);
    localparam int CNT_W     = clog2_min1(CFG_DEPTH + 1);
    localparam int PTR_W     = clog2_min1(CFG_DEPTH);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   ptr;
    logic [7:0]         pass;
    logic [7:0]         rep;
    logic [7:0]         dwell_cnt;
    logic [CW-1:0]      cfg_buf [CFG_DEPTH];

    logic               running;
    logic               cfg_wr_ok;
    logic               last_entry;
    logic               dwell_end;

    assign running    = (state == ST_RUN);
    assign cfg_full   = (count == CNT_W'(CFG_DEPTH));
    assign cfg_wr_ok  = (state == ST_IDLE) && cfg_we && !cfg_clr && !cfg_full;
    assign last_entry = (CNT_W'(ptr) == count - CNT_W'(1));
    assign dwell_end  = (dwell_cnt == cfg_active[DWELL_LSB +: DWELL_W]);

    always_ff @(posedge clk) begin
        if (!rst && cfg_wr_ok) cfg_buf[count[PTR_W-1:0]] <= cfg_wdata;
    end

    // Sequencer: cfg_active is registered so ownership switches exactly when the entry changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            ptr        <= '0;
            pass       <= '0;
            rep        <= '0;
            dwell_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_active <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_clr) count <= '0;
                    else if (cfg_wr_ok) count <= count + CNT_W'(1);
                    // A start that coincides with a clear would run an empty program, so drop it.
                    if (start && !cfg_clr && count != '0) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        ptr        <= '0;
                        pass       <= '0;
                        dwell_cnt  <= '0;
                        rep        <= repeat_n;
                        cfg_active <= cfg_buf[0];
                    end
                end
                ST_RUN: begin
                    if (dwell_end) begin
                        dwell_cnt <= '0;
                        if (!last_entry) begin
                            ptr        <= ptr + PTR_W'(1);
                            cfg_active <= cfg_buf[ptr + PTR_W'(1)];
                        end else if (pass != rep) begin
                            ptr        <= '0;
                            pass       <= pass + 8'd1;
                            cfg_active <= cfg_buf[0];
                        end else begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            cfg_active <= '0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [NUM_BG-1:0] own_sw;
    logic [NUM_BG-1:0] own_ex;
    logic [NUM_BG-1:0] ex_hit;
    logic [NUM_BG-1:0] b_we;
    logic [NUM_BG-1:0] b_re;
    logic [NUM_BG-1:0] b_rvalid;
    logic [NUM_BG-1:0] rd_by_sw;
    logic [AW-1:0]     b_addr  [NUM_BG];
    logic [DW-1:0]     b_wdata [NUM_BG];
    logic [DW-1:0]     b_rdata [NUM_BG];
    logic [DW-1:0]     sw_hold [NUM_BG];

    for (genvar g = 0; g < NUM_BG; g++) begin : g_bank
        // Outside RUN the external port owns everything; a disabled bank has no owner at all.
        assign own_sw[g] = running & cfg_active[EN_LSB + g] & cfg_active[SEL_LSB + g];
        assign own_ex[g] = !running | (cfg_active[EN_LSB + g] & !cfg_active[SEL_LSB + g]);
        assign ex_hit[g] = (ex_bank == BW'(g));

        assign b_we[g]    = !rst & (own_sw[g] ? sw_we[g] : (own_ex[g] & ex_hit[g] & ex_we));
        assign b_re[g]    = !rst & (own_sw[g] ? sw_re[g] : (own_ex[g] & ex_hit[g] & ex_re));
        assign b_addr[g]  = own_sw[g] ? sw_addr[g*AW +: AW]  : ex_addr;
        assign b_wdata[g] = own_sw[g] ? sw_wdata[g*DW +: DW] : ex_wdata;

        spm_bank #(
            .DW(DW),
            .AW(AW)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (b_we[g]),
            .re    (b_re[g]),
            .addr  (b_addr[g]),
            .wdata (b_wdata[g]),
            .rdata (b_rdata[g]),
            .rvalid(b_rvalid[g])
        );

        // Remember which port issued the read so the response is steered back to it.
        always_ff @(posedge clk) begin
            if (rst) rd_by_sw[g] <= 1'b0;
            else     rd_by_sw[g] <= own_sw[g] & sw_re[g];
        end

        assign sw_rvalid[g] = b_rvalid[g] & rd_by_sw[g];

        // Held copy keeps sw_rdata stable even if the external port later reads this bank.
        always_ff @(posedge clk) begin
            if (rst)               sw_hold[g] <= '0;
            else if (sw_rvalid[g]) sw_hold[g] <= b_rdata[g];
        end

        assign sw_rdata[g*DW +: DW] = sw_rvalid[g] ? b_rdata[g] : sw_hold[g];
    end

    logic          ex_ok;
    logic [BW-1:0] ex_rd_bank;
    logic [DW-1:0] ex_hold;

    assign ex_ok = |(own_ex & ex_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_err     <= 1'b0;
            ex_rd_bank <= '0;
        end else begin
            ex_err <= (ex_we | ex_re) & !ex_ok;
            if (ex_re & ex_ok) ex_rd_bank <= ex_bank;
        end
    end

    assign ex_rvalid = |(b_rvalid & ~rd_by_sw);
    assign ex_rdata  = ex_rvalid ? b_rdata[ex_rd_bank] : ex_hold;

    always_ff @(posedge clk) begin
        if (rst)            ex_hold <= '0;
        else if (ex_rvalid) ex_hold <= b_rdata[ex_rd_bank];
    end

endmodule
